// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared constants for the architectural register file and its neighbours.
// ROB_W tracks ROB_INDEX_BIT from const.v; keep the two in step when the ROB
// is resized.
//   XLEN      : data width
//   NREG      : architectural register count
//   REG_W     : register index width
//   ROB_W     : ROB index width
//   NUM_RD / ISSUE_W / COMMIT_W : default port counts
// ---------------------------------------------------------------------------
package rf_pkg;
    localparam int ROB_INDEX_BIT = 4;
    localparam int XLEN          = 32;
    localparam int NREG          = 32;
    localparam int REG_W         = $clog2(NREG);
    localparam int ROB_W         = ROB_INDEX_BIT;
    localparam int NUM_RD        = 4;
    localparam int ISSUE_W       = 2;
    localparam int COMMIT_W      = 2;
endpackage

// File: rtl/reg_status_file_if.sv
// ---------------------------------------------------------------------------
// reg_status_file_if
// Bundles the read, issue (dependency-set) and commit buses of the register
// file. Slot 0 of every multi-slot bus is the older instruction.
//   rd_id/rd_val/rd_dep/rd_has_dep : NUM_RD read ports
//   iss_id/iss_rob                 : ISSUE_W dependency-set ports (id 0 = none)
//   cm_id/cm_val/cm_rob            : COMMIT_W commit ports (id 0 = none)
// Modports: master = issue/ROB side, slave = register file.
// ---------------------------------------------------------------------------
interface reg_status_file_if #(
    parameter int XLEN     = rf_pkg::XLEN,
    parameter int NREG     = rf_pkg::NREG,
    parameter int ROB_W    = rf_pkg::ROB_W,
    parameter int NUM_RD   = rf_pkg::NUM_RD,
    parameter int ISSUE_W  = rf_pkg::ISSUE_W,
    parameter int COMMIT_W = rf_pkg::COMMIT_W
);
    import rf_pkg::*;

    localparam int RW = $clog2(NREG);

    logic [NUM_RD*RW-1:0]      rd_id;
    logic [NUM_RD*XLEN-1:0]    rd_val;
    logic [NUM_RD*ROB_W-1:0]   rd_dep;
    logic [NUM_RD-1:0]         rd_has_dep;
    logic [ISSUE_W*RW-1:0]     iss_id;
    logic [ISSUE_W*ROB_W-1:0]  iss_rob;
    logic [COMMIT_W*RW-1:0]    cm_id;
    logic [COMMIT_W*XLEN-1:0]  cm_val;
    logic [COMMIT_W*ROB_W-1:0] cm_rob;

    modport master (
        output rd_id, iss_id, iss_rob, cm_id, cm_val, cm_rob,
        input  rd_val, rd_dep, rd_has_dep
    );

    modport slave (
        input  rd_id, iss_id, iss_rob, cm_id, cm_val, cm_rob,
        output rd_val, rd_dep, rd_has_dep
    );
endinterface

// File: rtl/rf_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One combinational read port: selects val/dep/has_dep of register `id` from
// the state arrays, forcing x0 to zero.
// Optional feature macro: RF_COMMIT_BYPASS_EN -- when defined, a same-cycle
// commit that retires the register's pending producer is forwarded to the
// read (value from that commit, dependency cleared).
//   id                 : register index
//   val_q/dep_q/has_q  : current register state
//   cm_id/cm_val/cm_rob: same-cycle commit bus (used only by the bypass)
//   val/dep/has_dep    : read result
// ---------------------------------------------------------------------------
module rf_read_port #(
    parameter  int XLEN     = rf_pkg::XLEN,
    parameter  int NREG     = rf_pkg::NREG,
    parameter  int ROB_W    = rf_pkg::ROB_W,
    parameter  int COMMIT_W = rf_pkg::COMMIT_W,
    localparam int REG_W    = $clog2(NREG)
) (
    input  logic [REG_W-1:0]          id,
    input  logic [XLEN-1:0]           val_q [NREG],
    input  logic [ROB_W-1:0]          dep_q [NREG],
    input  logic [NREG-1:0]           has_q,
    input  logic [COMMIT_W*REG_W-1:0] cm_id,
    input  logic [COMMIT_W*XLEN-1:0]  cm_val,
    input  logic [COMMIT_W*ROB_W-1:0] cm_rob,
    output logic [XLEN-1:0]           val,
    output logic [ROB_W-1:0]          dep,
    output logic                      has_dep
);
    import rf_pkg::*;

    logic             byp_hit;
    logic [XLEN-1:0]  byp_val;

`ifdef RF_COMMIT_BYPASS_EN
    // Only the youngest commit slot naming this register decides the bypass,
    // so a later non-matching slot cancels an earlier match.
    always_comb begin
        byp_hit = 1'b0;
        byp_val = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (id != '0 && cm_id[k*REG_W +: REG_W] == id) begin
                byp_hit = has_q[id] && (dep_q[id] == cm_rob[k*ROB_W +: ROB_W]);
                byp_val = cm_val[k*XLEN +: XLEN];
            end
        end
    end
`else
    logic unused_cm;
    assign unused_cm = ^{cm_id, cm_val, cm_rob};
    assign byp_hit   = 1'b0;
    assign byp_val   = '0;
`endif

    always_comb begin
        val     = val_q[id];
        dep     = dep_q[id];
        has_dep = has_q[id];
        if (id == '0) begin
            val     = '0;
            dep     = '0;
            has_dep = 1'b0;
        end else if (byp_hit) begin
            val     = byp_val;
            dep     = '0;
            has_dep = 1'b0;
        end
    end
endmodule

// File: rtl/reg_status_file.sv
// ---------------------------------------------------------------------------
// reg_status_file
// Multi-ported architectural register file with per-register ROB dependency
// tags. Holds val/dep/has_dep for every register and applies ordered
// same-cycle commits (value write, tag retire) and issues (tag set).
// Optional feature macro: RF_COMMIT_BYPASS_EN (commit-to-read forwarding,
// implemented in rf_read_port).
//   clk_in : clock
//   rst_in : synchronous active-high reset, wins over everything
//   rdy_in : low freezes all state
//   clear  : misprediction flush, drops all tags and same-cycle updates
//   bus    : reg_status_file_if.slave (read, issue and commit buses)
// ---------------------------------------------------------------------------
module reg_status_file #(
    parameter int XLEN     = rf_pkg::XLEN,
    parameter int NREG     = rf_pkg::NREG,
    parameter int ROB_W    = rf_pkg::ROB_W,
    parameter int NUM_RD   = rf_pkg::NUM_RD,
    parameter int ISSUE_W  = rf_pkg::ISSUE_W,
    parameter int COMMIT_W = rf_pkg::COMMIT_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    reg_status_file_if.slave  bus
);
    import rf_pkg::*;

    localparam int RW = $clog2(NREG);

    logic [XLEN-1:0]  val_q [NREG];
    logic [XLEN-1:0]  val_d [NREG];
    logic [ROB_W-1:0] dep_q [NREG];
    logic [ROB_W-1:0] dep_d [NREG];
    logic [NREG-1:0]  has_q;
    logic [NREG-1:0]  has_d;
    logic [NREG-1:0]  iss_hit;

    logic [XLEN-1:0]  rv [NUM_RD];
    logic [ROB_W-1:0] rd [NUM_RD];
    logic [NUM_RD-1:0] rh;

    // Per-register next state. Slots are scanned oldest to youngest so the
    // youngest matching slot wins. Register 0 is never updated.
    always_comb begin
        val_d   = val_q;
        dep_d   = dep_q;
        has_d   = has_q;
        iss_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (bus.iss_id[i*RW +: RW] == RW'(r)) iss_hit[r] = 1'b1;
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (bus.cm_id[k*RW +: RW] == RW'(r)) begin
                    val_d[r] = bus.cm_val[k*XLEN +: XLEN];
                    // A commit retires the tag only if it is still the
                    // producer and no newer producer is issued this cycle.
                    if (!iss_hit[r] && has_q[r] &&
                        dep_q[r] == bus.cm_rob[k*ROB_W +: ROB_W]) begin
                        has_d[r] = 1'b0;
                        dep_d[r] = '0;
                    end
                end
            end
            for (int i = 0; i < ISSUE_W; i++) begin
                if (bus.iss_id[i*RW +: RW] == RW'(r)) begin
                    dep_d[r] = bus.iss_rob[i*ROB_W +: ROB_W];
                    has_d[r] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r] <= '0;
                dep_q[r] <= '0;
            end
            has_q <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int r = 0; r < NREG; r++) dep_q[r] <= '0;
                has_q <= '0;
            end else begin
                val_q <= val_d;
                dep_q <= dep_d;
                has_q <= has_d;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .NREG     (NREG),
            .ROB_W    (ROB_W),
            .COMMIT_W (COMMIT_W)
        ) u_port (
            .id      (bus.rd_id[p*RW +: RW]),
            .val_q   (val_q),
            .dep_q   (dep_q),
            .has_q   (has_q),
            .cm_id   (bus.cm_id),
            .cm_val  (bus.cm_val),
            .cm_rob  (bus.cm_rob),
            .val     (rv[p]),
            .dep     (rd[p]),
            .has_dep (rh[p])
        );
    end

    always_comb begin
        bus.rd_val     = '0;
        bus.rd_dep     = '0;
        bus.rd_has_dep = rh;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.rd_val[p*XLEN +: XLEN]  = rv[p];
            bus.rd_dep[p*ROB_W +: ROB_W] = rd[p];
        end
    end
endmodule
